uart_frame_rx: RTL

//  Receive-side framer that consumes bytes from the uart receiver (rdy/dout/rdy_clr handshake) and rebuilds framed messages.

---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/uart_rx_byte_if.sv | 45 ++++
 rtl/uart_frame_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive framer: start-of-frame marker,
// FSM state encoding, error-bit positions and a small state helper.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // Bit positions inside the registered error-pulse vector
    localparam int ERR_CHK = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_TMO = 2;
    localparam int ERR_OVR = 3;
    localparam int ERR_W   = 4;

    // States in which the inter-byte gap is policed
    function automatic logic is_timed(input state_t s);
        return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Handshake adapter for the uart receiver: takes a byte when rx_rdy is up,
// acknowledges it with a one-cycle rx_rdy_clr pulse and presents it to the
// framer as a single-cycle strobe with registered data.
module uart_rx_byte_if (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_rdy_clr,
    output logic       byte_stb,
    output logic [7:0] byte_data
);

    logic       clr_reg;
    logic       block_reg;
    logic       stb_reg;
    logic [7:0] data_reg;
    logic       accept;

    // The ack cycle and the cycle after it are blind, so a receiver that is
    // slow to drop rx_rdy never gets the same byte counted twice.
    assign accept = rx_rdy && !clr_reg && !block_reg;

    // Capture the byte, raise the ack pulse and the strobe for the framer
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            clr_reg   <= 1'b0;
            block_reg <= 1'b0;
            stb_reg   <= 1'b0;
            data_reg  <= 8'h00;
        end else begin
            clr_reg   <= accept;
            block_reg <= clr_reg;
            stb_reg   <= accept;
            if (accept) begin
                data_reg <= rx_data;
            end
        end
    end

    assign rx_rdy_clr = clr_reg;
    assign byte_stb   = stb_reg;
    assign byte_data  = data_reg;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame rebuilder: SOF, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
// Holds one checked frame for the application and flags checksum, length,
// inter-byte timeout and overrun errors as single-cycle pulses.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN     = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   rx_rdy_clr,
    output logic                   frame_valid,
    output logic [3:0]             frame_len,
    output logic [8*MAX_LEN-1:0]   frame_data,
    input  logic                   frame_ack,
    output logic                   chk_err,
    output logic                   len_err,
    output logic                   timeout,
    output logic                   overrun
);

    localparam int            TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    logic             byte_stb;
    logic [7:0]       byte_data;

    state_t           state_reg, state_next;
    logic [3:0]       len_reg, len_next;
    logic [3:0]       idx_reg, idx_next;
    logic [7:0]       xor_reg, xor_next;
    logic [TW-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic [ERR_W-1:0] err_reg, err_next;
    logic             frame_valid_reg, frame_valid_next;
    logic             len_ok, tmo_hit, data_clr, data_wr;
    logic [7:0]       lane_reg [MAX_LEN];

    uart_rx_byte_if u_byte_if (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .byte_stb   (byte_stb),
        .byte_data  (byte_data)
    );

    assign len_ok  = (byte_data != 8'h00) && (byte_data <= MAX_LEN_B);
    assign tmo_hit = is_timed(state_reg) && !byte_stb && (tmo_cnt_reg == TMO_LAST);

    // State, control datapath and registered outputs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            len_reg         <= 4'd0;
            idx_reg         <= 4'd0;
            xor_reg         <= 8'h00;
            tmo_cnt_reg     <= '0;
            err_reg         <= '0;
            frame_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            len_reg         <= len_next;
            idx_reg         <= idx_next;
            xor_reg         <= xor_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            err_reg         <= err_next;
            frame_valid_reg <= frame_valid_next;
        end
    end

    // Next-state decode; a timeout overrides whatever the byte would do
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (byte_stb && byte_data == SOF_BYTE) state_next = ST_LEN;
            ST_LEN:     if (byte_stb) state_next = len_ok ? ST_PAYLOAD : ST_IDLE;
            ST_PAYLOAD: if (byte_stb && idx_reg == len_reg - 4'd1) state_next = ST_CHK;
            ST_CHK:     if (byte_stb) state_next = (byte_data == xor_reg) ? ST_HOLD : ST_IDLE;
            ST_HOLD:    if (frame_ack && frame_valid_reg) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_next = ST_IDLE;
        end
    end

    // Length, index, running checksum and gap counter updates
    always_comb begin
        len_next = len_reg;
        idx_next = idx_reg;
        xor_next = xor_reg;
        data_clr = 1'b0;
        data_wr  = 1'b0;
        if (byte_stb) begin
            case (state_reg)
                ST_IDLE: if (byte_data == SOF_BYTE) begin
                    idx_next = 4'd0;
                    xor_next = 8'h00;
                    data_clr = 1'b1;
                end
                ST_LEN: if (len_ok) begin
                    len_next = byte_data[3:0];
                    xor_next = byte_data;
                end
                ST_PAYLOAD: begin
                    data_wr  = 1'b1;
                    xor_next = xor_reg ^ byte_data;
                    idx_next = idx_reg + 4'd1;
                end
                default: ;
            endcase
        end
        // Counter restarts on every accepted byte and on every state change
        if (is_timed(state_next) && state_next == state_reg && !byte_stb) begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end else begin
            tmo_cnt_next = '0;
        end
    end

    // Output decode: error pulses and the frame-valid flag
    always_comb begin
        err_next          = '0;
        frame_valid_next  = (state_reg == ST_HOLD) && !(frame_ack && frame_valid_reg);
        if (byte_stb) begin
            case (state_reg)
                ST_LEN:  err_next[ERR_LEN] = !len_ok;
                ST_CHK:  err_next[ERR_CHK] = (byte_data != xor_reg);
                ST_HOLD: err_next[ERR_OVR] = 1'b1;
                default: ;
            endcase
        end
        err_next[ERR_TMO] = tmo_hit;
    end

    // One payload register per byte lane; the output only shows a checked frame
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_lane
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg[gi] <= 8'h00;
                end else if (data_clr) begin
                    lane_reg[gi] <= 8'h00;
                end else if (data_wr && idx_reg == 4'(gi)) begin
                    lane_reg[gi] <= byte_data;
                end
            end
            assign frame_data[8*gi +: 8] = frame_valid_reg ? lane_reg[gi] : 8'h00;
        end
    endgenerate

    assign frame_valid = frame_valid_reg;
    assign frame_len   = frame_valid_reg ? len_reg : 4'd0;
    assign chk_err     = err_reg[ERR_CHK];
    assign len_err     = err_reg[ERR_LEN];
    assign timeout     = err_reg[ERR_TMO];
    assign overrun     = err_reg[ERR_OVR];

endmodule
